// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for mem_access_unit: memory function codes, FSM state
// encoding and the unshifted byte-enable pattern for each access size.
package mem_access_pkg;

    localparam logic [2:0] FUNC_B  = 3'b000;
    localparam logic [2:0] FUNC_H  = 3'b001;
    localparam logic [2:0] FUNC_W  = 3'b010;
    localparam logic [2:0] FUNC_BU = 3'b100;
    localparam logic [2:0] FUNC_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_e;

    // The low two func bits encode the access size for both signed and unsigned codes.
    function automatic logic [3:0] base_be(input logic [1:0] size);
        case (size)
            2'b00:   base_be = 4'b0001;
            2'b01:   base_be = 4'b0011;
            2'b10:   base_be = 4'b1111;
            default: base_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles for mem_access_unit: the execute-side request/response channel and
// the data-memory request/grant/response port.
interface lsu_req_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_func;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_store, req_func, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_store, req_func, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Load data formatter: shifts the two-beat read window down by the byte
// offset, then extracts and sign- or zero-extends according to the func code.
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata64,
    input  logic [1:0]  off,
    input  logic [2:0]  func,
    output logic [31:0] rdata
);

    logic        [31:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted = 32'(rdata64 >> {off, 3'b000});
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (func)
            FUNC_B:  rdata = 32'(byte_s);
            FUNC_H:  rdata = 32'(half_s);
            FUNC_W:  rdata = shifted;
            FUNC_BU: rdata = {24'b0, shifted[7:0]};
            FUNC_HU: rdata = {16'b0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one load or store into word-aligned memory beats.
// Build option MISALIGNED_SPLIT_EN splits misaligned H/W accesses into two beats.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req_if,
    lsu_mem_if.master mem_if
);

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        func_q, func_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [31:0]       rd0_q, rd0_d;

    logic [3:0]        be_lo;
    logic [31:0]       wd_lo;
    logic              illegal;
    logic              reject;
    logic [63:0]       fmt_in;
    logic [31:0]       fmt_rdata;

`ifdef MISALIGNED_SPLIT_EN
    logic [31:0]       rd1_q, rd1_d;
    logic [3:0]        be_hi_q, be_hi_d;
    logic [31:0]       wd_hi_q, wd_hi_d;
    logic [7:0]        be64;
    logic [63:0]       wd64;

    // Lanes that spill past the word boundary become the second beat.
    always_comb begin
        be64 = {4'b0000, base_be(req_if.req_func[1:0])} << req_if.req_addr[1:0];
        wd64 = {32'b0, req_if.req_wdata} << {req_if.req_addr[1:0], 3'b000};
    end
    assign be_lo  = be64[3:0];
    assign wd_lo  = wd64[31:0];
    assign reject = illegal;
    assign fmt_in = {rd1_d, rd0_d};
`else
    logic misaligned;

    always_comb begin
        be_lo = base_be(req_if.req_func[1:0]) << req_if.req_addr[1:0];
        wd_lo = req_if.req_wdata << {req_if.req_addr[1:0], 3'b000};
        misaligned = ((req_if.req_func[1:0] == 2'b01) && (req_if.req_addr[1:0] == 2'b11)) ||
                     ((req_if.req_func[1:0] == 2'b10) && (req_if.req_addr[1:0] != 2'b00));
    end
    assign reject = illegal || misaligned;
    assign fmt_in = {32'b0, rd0_d};
`endif

    // Stores only allow B/H/W; loads additionally allow BU/HU.
    always_comb begin
        if (req_if.req_store)
            illegal = !(req_if.req_func inside {FUNC_B, FUNC_H, FUNC_W});
        else
            illegal = req_if.req_func inside {3'b011, 3'b110, 3'b111};
    end

    load_formatter u_load_formatter (
        .rdata64 (fmt_in),
        .off     (off_q),
        .func    (func_q),
        .rdata   (fmt_rdata)
    );

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        func_d      = func_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rd0_d       = rd0_q;
`ifdef MISALIGNED_SPLIT_EN
        rd1_d       = rd1_q;
        be_hi_d     = be_hi_q;
        wd_hi_d     = wd_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    store_d = req_if.req_store;
                    func_d  = req_if.req_func;
                    off_d   = req_if.req_addr[1:0];
`ifdef MISALIGNED_SPLIT_EN
                    be_hi_d = be64[7:4];
                    wd_hi_d = wd64[63:32];
`endif
                    if (reject) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_if.req_store;
                        mem_addr_d  = {req_if.req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = be_lo;
                        mem_wdata_d = wd_lo;
                    end
                end
            end
            REQ0: begin
                if (mem_if.mem_gnt) begin
                    state_d   = WAIT0;
                    mem_req_d = 1'b0;
                end
            end
            WAIT0: begin
                if (mem_if.mem_rvalid) begin
                    rd0_d = mem_if.mem_rdata;
`ifdef MISALIGNED_SPLIT_EN
                    if (be_hi_q != 4'b0000) begin
                        state_d     = REQ1;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wd_hi_q;
                    end else begin
`else
                    begin
`endif
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = store_q ? 32'b0 : fmt_rdata;
                    end
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            REQ1: begin
                if (mem_if.mem_gnt) begin
                    state_d   = WAIT1;
                    mem_req_d = 1'b0;
                end
            end
            WAIT1: begin
                if (mem_if.mem_rvalid) begin
                    rd1_d       = mem_if.mem_rdata;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = store_q ? 32'b0 : fmt_rdata;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            func_q      <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd0_q       <= '0;
`ifdef MISALIGNED_SPLIT_EN
            rd1_q       <= '0;
            be_hi_q     <= '0;
            wd_hi_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            func_q      <= func_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd0_q       <= rd0_d;
`ifdef MISALIGNED_SPLIT_EN
            rd1_q       <= rd1_d;
            be_hi_q     <= be_hi_d;
            wd_hi_q     <= wd_hi_d;
`endif
        end
    end

    assign req_if.req_ready  = (state_q == IDLE);
    assign req_if.rsp_valid  = rsp_valid_q;
    assign req_if.rsp_err    = rsp_err_q;
    assign req_if.rsp_rdata  = rsp_rdata_q;
    assign mem_if.mem_req    = mem_req_q;
    assign mem_if.mem_we     = mem_we_q;
    assign mem_if.mem_addr   = mem_addr_q;
    assign mem_if.mem_be     = mem_be_q;
    assign mem_if.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores with a scripted
// memory responder; expected beats and responses are queued at issue time.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    rsp_t  mon_r;

    lsu_req_if #(.ADDR_W(32)) rq();
    lsu_mem_if #(.ADDR_W(32)) mb();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (rq),
        .mem_if (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rq.rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected rsp_valid", 96'(rq.rsp_valid), 96'd0);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_err", 96'(rq.rsp_err), 96'(mon_r.err));
                chk("rsp_rdata", 96'(rq.rsp_rdata), 96'(mon_r.rdata));
                chk("rsp cycle", 96'(cyc), 96'(mon_r.due));
            end
        end
    end

    // Memory responder: checks each beat against the queue, then grants and answers
    initial begin : responder
        beat_t       b;
        logic [69:0] snap;
        mb.mem_gnt    = 1'b0;
        mb.mem_rvalid = 1'b0;
        mb.mem_rdata  = '0;
        @(negedge clk);
        forever begin
            if (!(rst_n === 1'b1 && mb.mem_req === 1'b1)) begin
                @(negedge clk);
            end else if (beat_q.size() == 0) begin
                chk("unexpected mem_req", 96'(mb.mem_req), 96'd0);
                mb.mem_gnt = 1'b1;
                @(negedge clk);
                mb.mem_gnt    = 1'b0;
                mb.mem_rvalid = 1'b1;
                mb.mem_rdata  = '0;
                @(negedge clk);
                mb.mem_rvalid = 1'b0;
            end else begin
                b = beat_q.pop_front();
                chk("mem_addr", 96'(mb.mem_addr), 96'(b.addr));
                chk("mem_be", 96'(mb.mem_be), 96'(b.be));
                chk("mem_we", 96'(mb.mem_we), 96'(b.we));
                chk("mem_wdata", 96'(mb.mem_wdata), 96'(b.wdata));
                snap = {mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_be, mb.mem_wdata};
                for (int i = 0; i < b.gnt_dly; i++) begin
                    @(negedge clk);
                    chk("mem stable in stall",
                        96'({mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_be, mb.mem_wdata}),
                        96'(snap));
                end
                mb.mem_gnt = 1'b1;
                @(negedge clk);
                mb.mem_gnt = 1'b0;
                repeat (b.rv_dly) @(negedge clk);
                mb.mem_rvalid = 1'b1;
                mb.mem_rdata  = b.rdata;
                @(negedge clk);
                mb.mem_rvalid = 1'b0;
            end
        end
    end

    task automatic add_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rvd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.rdata = rd;
        b.gnt_dly = gd; b.rv_dly = rvd;
        beat_q.push_back(b);
    endtask

    task automatic issue(input logic st, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] wd, input bit want_rsp, input logic e_err,
                         input logic [31:0] e_rd, input int lat);
        rsp_t r;
        @(negedge clk);
        chk("req_ready when idle", 96'(rq.req_ready), 96'd1);
        rq.req_valid = 1'b1;
        rq.req_store = st;
        rq.req_func  = fn;
        rq.req_addr  = a;
        rq.req_wdata = wd;
        if (want_rsp) begin
            r.err = e_err; r.rdata = e_rd; r.due = cyc + lat;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        rq.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (rsp_q.size() == 0 && beat_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain timeout", 96'(rsp_q.size() + beat_q.size()), 96'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not complete, checks so far %0d", n_chk);
        $fatal(1);
    end

    initial begin : main
        n_chk = 0; n_pass = 0; cyc = 0;
        rst_n = 1'b0;
        rq.req_valid = 1'b0; rq.req_store = 1'b0; rq.req_func = 3'b000;
        rq.req_addr = '0; rq.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset req_ready", 96'(rq.req_ready), 96'd1);
        chk("reset mem_req", 96'(mb.mem_req), 96'd0);
        chk("reset rsp_valid", 96'(rq.rsp_valid), 96'd0);
        chk("reset rsp_rdata", 96'(rq.rsp_rdata), 96'd0);
        chk("reset mem_addr_be", 96'({mb.mem_addr, mb.mem_be}), 96'd0);

        // LW aligned, zero-wait
        add_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'h800000F0, 0, 0);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1, 1'b0, 32'h800000F0, 3);
        wait_done();

        // LB / LBU on the top lane
        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80ABCDEF, 0, 0);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 32'hFFFFFF80, 3);
        wait_done();
        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80ABCDEF, 0, 0);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0, 32'h00000080, 3);
        wait_done();

        // SH to upper half
        add_beat(32'h200, 4'b1100, 1'b1, 32'h12340000, 32'hDEADBEEF, 0, 0);
        issue(1'b1, 3'b001, 32'h202, 32'h00001234, 1, 1'b0, 32'h0, 3);
        wait_done();

        // Misaligned LW across a word boundary
`ifdef MISALIGNED_SPLIT_EN
        add_beat(32'hFFC, 4'b1100, 1'b0, 32'h0, 32'hAAAA1111, 0, 0);
        add_beat(32'h1000, 4'b0011, 1'b0, 32'h0, 32'h2222BBBB, 0, 0);
        issue(1'b0, 3'b010, 32'hFFE, 32'h0, 1, 1'b0, 32'hBBBBAAAA, 5);
`else
        issue(1'b0, 3'b010, 32'hFFE, 32'h0, 1, 1'b1, 32'h0, 1);
`endif
        wait_done();

        // Misaligned SW wrapping the address space
`ifdef MISALIGNED_SPLIT_EN
        add_beat(32'hFFFFFFFC, 4'b1110, 1'b1, 32'h22334400, 32'h0, 0, 0);
        add_beat(32'h00000000, 4'b0001, 1'b1, 32'h00000011, 32'h0, 0, 0);
        issue(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 1, 1'b0, 32'h0, 5);
`else
        issue(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 1, 1'b1, 32'h0, 1);
`endif
        wait_done();

        // Misaligned LH at offset 3
`ifdef MISALIGNED_SPLIT_EN
        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'hAB000000, 0, 0);
        add_beat(32'h104, 4'b0001, 1'b0, 32'h0, 32'h000000CD, 0, 0);
        issue(1'b0, 3'b001, 32'h103, 32'h0, 1, 1'b0, 32'hFFFFCDAB, 5);
`else
        issue(1'b0, 3'b001, 32'h103, 32'h0, 1, 1'b1, 32'h0, 1);
`endif
        wait_done();

        // LH with 5 grant-stall cycles and 2 rvalid-delay cycles
        add_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 5, 2);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 1, 1'b0, 32'hFFFF8001, 10);
        wait_done();

        // LHU, same word
        add_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 0, 0);
        issue(1'b0, 3'b101, 32'h102, 32'h0, 1, 1'b0, 32'h00008001, 3);
        wait_done();

        // Reset while waiting for read data; the late rvalid must be ignored
        add_beat(32'h300, 4'b1111, 1'b0, 32'h0, 32'h55555555, 0, 3);
        issue(1'b0, 3'b010, 32'h300, 32'h0, 0, 1'b0, 32'h0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset mem_req", 96'(mb.mem_req), 96'd0);
        chk("async reset rsp_valid", 96'(rq.rsp_valid), 96'd0);
        chk("async reset req_ready", 96'(rq.req_ready), 96'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no rsp after reset", 96'({rq.rsp_valid, mb.mem_req}), 96'd0);
        end
        wait_done();

        // LB after reset
        add_beat(32'h000, 4'b0010, 1'b0, 32'h0, 32'h00007F00, 0, 0);
        issue(1'b0, 3'b000, 32'h001, 32'h0, 1, 1'b0, 32'h0000007F, 3);
        wait_done();

        // Illegal: store with unsigned func, load with func 111
        issue(1'b1, 3'b100, 32'h040, 32'hCAFEF00D, 1, 1'b1, 32'h0, 1);
        wait_done();
        issue(1'b0, 3'b111, 32'h040, 32'h0, 1, 1'b1, 32'h0, 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
